// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the fetch stage
//
// Purpose: word type, fetch FSM state encoding and the default reset PC.

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

    localparam word_t WORD_BYTES = 32'd4;

    // Sequential successor of a fetch address; wraps silently at the top of memory.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + WORD_BYTES;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage feeding the IF/ID latch
//
// Purpose: owns the PC, issues icache reads (imemREN/imemaddr, completed by ihit)
// and hands instruction, PC+4 and predicted next PC to IF/ID with an update strobe.
// EX/MEM redirects and halt are applied here; fd_flush mirrors redirect_valid.
//
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   ihit, iload            icache completion and instruction word for imemaddr
//   imemREN, imemaddr      icache read request and byte address
//   stall                  IF/ID cannot accept this cycle
//   redirect_valid/_pc     taken branch/jump target from EX/MEM
//   halt                   stop fetching until reset
//   fd_instr, fd_normal_pc, fd_next_pc, fd_update, fd_flush   IF/ID interface

module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_normal_pc,
    output logic [31:0] fd_next_pc,
    output logic        fd_update,
    output logic        fd_flush
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n;
    word_t        req_pc, req_pc_n;
    word_t        buf_instr, buf_instr_n;
    word_t        buf_pc, buf_pc_n;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_pc_n     = req_pc;
        buf_instr_n  = buf_instr;
        buf_pc_n     = buf_pc;

        imemREN      = 1'b0;
        imemaddr     = pc;
        fd_instr     = iload;
        fd_normal_pc = pc_plus4(pc);
        fd_update    = 1'b0;
        fd_flush     = redirect_valid && (state != HALTED);

        unique case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (!ihit) begin
                        // The icache still owns the old request; keep presenting
                        // its address until it completes, then discard the word.
                        req_pc_n = pc;
                        state_n  = SQUASH;
                    end
                end else if (ihit) begin
                    pc_n = pc_plus4(pc);
                    if (!stall) begin
                        fd_update = 1'b1;
                    end else begin
                        buf_instr_n = iload;
                        buf_pc_n    = pc;
                        state_n     = HOLD;
                    end
                end
            end

            HOLD: begin
                fd_instr     = buf_instr;
                fd_normal_pc = pc_plus4(buf_pc);
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = FETCH;
                end else if (!stall) begin
                    fd_update = 1'b1;
                    state_n   = FETCH;
                end
            end

            SQUASH: begin
                imemREN  = 1'b1;
                imemaddr = req_pc;
                if (halt) begin
                    state_n = HALTED;
                end else begin
                    // A later redirect replaces the earlier target; the pending
                    // request completing on the same cycle still ends the squash.
                    if (redirect_valid) begin
                        pc_n = redirect_pc;
                    end
                    if (ihit) begin
                        state_n = FETCH;
                    end
                end
            end

            HALTED: begin
                fd_flush = 1'b0;
            end

            default: begin
                state_n = FETCH;
            end
        endcase

        fd_next_pc = fd_normal_pc;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            pc        <= PC_INIT;
            req_pc    <= PC_INIT;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_pc    <= req_pc_n;
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage

module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, redirect_valid, halt;
    logic [31:0] iload, redirect_pc;
    logic        imemREN, fd_update, fd_flush;
    logic [31:0] imemaddr, fd_instr, fd_normal_pc, fd_next_pc;

    logic        w_imemREN, w_fd_update, w_fd_flush;
    logic [31:0] w_imemaddr, w_iload, w_fd_instr, w_fd_normal_pc, w_fd_next_pc;
    logic        w_ihit = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;

    always #5 CLK = ~CLK;

    function automatic word_t word_at(input word_t a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign iload   = word_at(imemaddr);
    assign w_iload = word_at(w_imemaddr);

    fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fd_instr(fd_instr), .fd_normal_pc(fd_normal_pc), .fd_next_pc(fd_next_pc),
        .fd_update(fd_update), .fd_flush(fd_flush)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
        .CLK(CLK), .nRST(nRST), .ihit(w_ihit), .iload(w_iload),
        .imemREN(w_imemREN), .imemaddr(w_imemaddr), .stall(w_zero),
        .redirect_valid(w_zero), .redirect_pc(w_zero32), .halt(w_zero),
        .fd_instr(w_fd_instr), .fd_normal_pc(w_fd_normal_pc), .fd_next_pc(w_fd_next_pc),
        .fd_update(w_fd_update), .fd_flush(w_fd_flush)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_updates = 0;
    logic  halted_flag = 1'b0;
    word_t exp_pc = '0;
    word_t redir_q[$];   // pending stream starts: reset PC or redirect targets

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every IF/ID update must carry the next word of the current
    // sequential stream, which restarts at the latest redirect target.
    always @(negedge CLK) begin
        if (nRST) begin
            check("excl_upd_flush", {31'b0, fd_update && fd_flush}, 32'h0);
            check("flush_passthru", {31'b0, fd_flush}, {31'b0, redirect_valid && !halted_flag});
            if (fd_update) begin
                if (redir_q.size() > 0) begin
                    exp_pc = redir_q[$];
                    redir_q.delete();
                end
                check("upd_while_stall", {31'b0, stall}, 32'h0);
                check("sb_instr", fd_instr, word_at(exp_pc));
                check("sb_normal_pc", fd_normal_pc, exp_pc + 32'd4);
                check("sb_next_pc", fd_next_pc, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_updates++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive(input logic ih, input logic st, input logic rv,
                         input word_t rpc, input logic hl);
        ihit = ih; stall = st; redirect_valid = rv; redirect_pc = rpc; halt = hl;
        if (rv) redir_q.push_back(rpc);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        halted_flag = 1'b0;
        redir_q.delete();
        redir_q.push_back(32'h0);
        sample();
        check("rst_ren", {31'b0, imemREN}, 32'h1);
        check("rst_addr", imemaddr, 32'h0);
        check("rst_upd", {31'b0, fd_update}, 32'h0);
        check("rst_flush", {31'b0, fd_flush}, 32'h0);
        check("rst_wrap_addr", w_imemaddr, 32'hFFFF_FFFC);
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;

        // Streaming fetch, one instruction per cycle; wrap instance alongside.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            sample();
            check("t1_addr", imemaddr, 32'(4 * k));
            check("t1_upd", {31'b0, fd_update}, 32'h1);
            check("t1_npc", fd_normal_pc, 32'(4 * k + 4));
            if (k == 0) begin
                check("t6_addr0", w_imemaddr, 32'hFFFF_FFFC);
                check("t6_npc0", w_fd_normal_pc, 32'h0);
                check("t6_upd0", {31'b0, w_fd_update}, 32'h1);
            end
            if (k == 1) check("t6_addr1", w_imemaddr, 32'h0);
            tick();
        end

        // Stall on the word at 0x8 for three cycles.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        sample();
        check("t2_addr8", imemaddr, 32'h8);
        check("t2_upd_stall", {31'b0, fd_update}, 32'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            sample();
            check("t2_hold_ren", {31'b0, imemREN}, 32'h0);
            check("t2_hold_instr", fd_instr, word_at(32'h8));
            check("t2_hold_upd", {31'b0, fd_update}, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("t2_release_upd", {31'b0, fd_update}, 32'h1);
        check("t2_release_instr", fd_instr, word_at(32'h8));
        check("t2_release_npc", fd_normal_pc, 32'hC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("t2_next_addr", imemaddr, 32'hC);
        tick();

        // Redirect while the request at 0x10 is outstanding.
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        sample();
        check("t3_flush", {31'b0, fd_flush}, 32'h1);
        check("t3_addr", imemaddr, 32'h10);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("t3_sq_addr", imemaddr, 32'h10);
        check("t3_sq_ren", {31'b0, imemREN}, 32'h1);
        check("t3_sq_flush", {31'b0, fd_flush}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("t3_sq_hit_addr", imemaddr, 32'h10);
        check("t3_sq_hit_upd", {31'b0, fd_update}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("t3_target_addr", imemaddr, 32'h40);
        check("t3_target_upd", {31'b0, fd_update}, 32'h1);
        tick();

        // Redirect coinciding with ihit.
        drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        sample();
        check("t4_addr", imemaddr, 32'h20);
        check("t4_upd", {31'b0, fd_update}, 32'h0);
        check("t4_flush", {31'b0, fd_flush}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        sample();
        check("t4_next_addr", imemaddr, 32'h100);
        tick();

        // Halt while holding, then halt while fetching.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        sample();
        check("t5_hold_halt_ren", {31'b0, imemREN}, 32'h0);
        check("t5_hold_halt_upd", {31'b0, fd_update}, 32'h0);
        tick();
        halted_flag = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            sample();
            check("t5_halted_ren", {31'b0, imemREN}, 32'h0);
            check("t5_halted_upd", {31'b0, fd_update}, 32'h0);
            check("t5_halted_flush", {31'b0, fd_flush}, 32'h0);
            tick();
        end
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        sample();
        check("t5_fetch_halt_upd", {31'b0, fd_update}, 32'h0);
        tick();
        halted_flag = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            sample();
            check("t5_fh_ren", {31'b0, imemREN}, 32'h0);
            check("t5_fh_upd", {31'b0, fd_update}, 32'h0);
            tick();
        end

        // Reset in the middle of a hold.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("t5_restart_addr", imemaddr, 32'h0);
        check("t5_restart_upd", {31'b0, fd_update}, 32'h1);
        tick();

        // Randomized traffic against the stream scoreboard.
        do_reset();
        n_updates = 0;
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        sample();
        check("rnd_progress", {31'b0, n_updates > 40}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
